// File: rtl/tl_ctrl_param.sv
// tl_ctrl_param: highway/farm traffic-light controller with internal timers, all-red clearance, state strobe; optional night blink via NIGHT_MODE_EN
//   clk, reset (sync, active-high), c (farm car present), night (NIGHT_MODE_EN only)
//   HG/HY/HR, FG/FY/FR lamps decoded from state; st_o new-state strobe; state_o, cnt_o observation
module tl_ctrl_param #(
  parameter int TW       = 8,
  parameter int LONG_T   = 20,
  parameter int SHORT_T  = 4,
  parameter int ALLRED_T = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c,
`ifdef NIGHT_MODE_EN
  input  logic          night,
`endif
  output logic          HG,
  output logic          HY,
  output logic          HR,
  output logic          FG,
  output logic          FY,
  output logic          FR,
  output logic          st_o,
  output logic [2:0]    state_o,
  output logic [TW-1:0] cnt_o
);
  localparam logic [2:0] S_HG = 3'd0, S_HY = 3'd1, S_AR1 = 3'd2, S_FG = 3'd3;
  localparam logic [2:0] S_FY = 3'd4, S_AR2 = 3'd5, S_NIGHT = 3'd6;
  localparam logic [TW-1:0] L1 = TW'(LONG_T - 1);
  localparam logic [TW-1:0] S1 = TW'(SHORT_T - 1);
  localparam logic [TW-1:0] A1 = TW'(ALLRED_T - 1);
  logic [2:0] state, nxt;
  logic [TW-1:0] cnt;
  logic st, reload, blink;
`ifdef NIGHT_MODE_EN
  logic req, ph;
  // night blink re-arms the counter every half-period without leaving the state
  assign reload = state == S_NIGHT && cnt == S1;
  assign blink = state == S_NIGHT && ph;
  always_ff @(posedge clk)
    if (reset) begin
      req <= 1'b0;
      ph <= 1'b0;
    end else begin
      req <= (state == S_HG && night) ? 1'b1 : (state == S_HY && nxt != S_HY) ? 1'b0 : req;
      ph <= (nxt == S_NIGHT && state != S_NIGHT) ? 1'b1 : reload ? ~ph : ph;
    end
`else
  assign reload = 1'b0;
  assign blink = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_HG;
      cnt <= '0;
      st <= 1'b0;
    end else begin
      state <= nxt;
      st <= nxt != state;
      cnt <= (nxt != state || reload) ? '0 : (cnt == '1) ? cnt : cnt + 1'b1;
    end
  always_comb begin
    nxt = S_HG;
    case (state)
`ifdef NIGHT_MODE_EN
      S_HG:    nxt = (night || (c && cnt >= L1)) ? S_HY : S_HG;
      S_HY:    nxt = (cnt == S1) ? (req ? S_NIGHT : S_AR1) : S_HY;
      S_NIGHT: nxt = night ? S_NIGHT : S_AR2;
`else
      S_HG:    nxt = (c && cnt >= L1) ? S_HY : S_HG;
      S_HY:    nxt = (cnt == S1) ? S_AR1 : S_HY;
`endif
      S_AR1:   nxt = (cnt == A1) ? S_FG : S_AR1;
      S_FG:    nxt = (!c || cnt >= L1) ? S_FY : S_FG;
      S_FY:    nxt = (cnt == S1) ? S_AR2 : S_FY;
      S_AR2:   nxt = (cnt == A1) ? S_HG : S_AR2;
      default: nxt = S_HG;
    endcase
  end
  always_comb begin
    HG = state == S_HG;
    HY = state == S_HY || blink;
    HR = state == S_AR1 || state == S_FG || state == S_FY || state == S_AR2;
    FG = state == S_FG;
    FY = state == S_FY;
    FR = state == S_HG || state == S_HY || state == S_AR1 || state == S_AR2 || blink;
    st_o = st;
    state_o = state;
    cnt_o = cnt;
  end
endmodule

// File: tb/tb_tl_ctrl_param.sv
// tb_tl_ctrl_param: table-driven check of tl_ctrl_param with default parameters
module tb_tl_ctrl_param;
  logic clk = 0, reset = 1, c = 0, night = 0;
  logic HG, HY, HR, FG, FY, FR, st_o;
  logic [2:0] state_o;
  logic [7:0] cnt_o;
  int checks = 0, errors = 0;

  tl_ctrl_param dut (
    .clk(clk), .reset(reset), .c(c),
`ifdef NIGHT_MODE_EN
    .night(night),
`endif
    .HG(HG), .HY(HY), .HR(HR), .FG(FG), .FY(FY), .FR(FR),
    .st_o(st_o), .state_o(state_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, cv, nv;
    int n;
    logic [2:0] s;
    int cn;
    logic st, ph;
  } vec_t;
  vec_t tv[$];

  // expected {HG,HY,HR,FG,FY,FR}
  function automatic logic [5:0] lamps(input logic [2:0] s, input logic ph);
    case (s)
      3'd0: return 6'b100_001;
      3'd1: return 6'b010_001;
      3'd2: return 6'b001_001;
      3'd3: return 6'b001_100;
      3'd4: return 6'b001_010;
      3'd5: return 6'b001_001;
      3'd6: return {1'b0, ph, 3'b000, ph};
      default: return 6'b000_000;
    endcase
  endfunction

  function automatic void add(input logic r, input logic cv, input logic nv, input int n,
                              input logic [2:0] s, input int cn, input logic st, input logic ph = 1'b0);
    vec_t v;
    v.rst = r; v.cv = cv; v.nv = nv; v.n = n; v.s = s; v.cn = cn; v.st = st; v.ph = ph;
    tv.push_back(v);
  endfunction

  task automatic check(input string name, input logic [2:0] s, input int cn, input logic st, input logic ph);
    logic [18:0] act, exp;
    act = {state_o, cnt_o, st_o, HG, HY, HR, FG, FY, FR};
    exp = {s, 8'(cn), st, lamps(s, ph)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d cnt=%0d st=%b lamps=%b, want state=%0d cnt=%0d st=%b lamps=%b",
               name, act[18:16], act[15:8], act[7], act[5:0], exp[18:16], exp[15:8], exp[7], exp[5:0]);
    end
  endtask

  initial begin
    // reset, then c=1 from reset: HG 0-19, HY 20-23, AR1 24-25, FG from 26
    add(1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 19, 0, 19, 0);
    add(0, 1, 0, 1, 1, 0, 1);
    add(0, 1, 0, 3, 1, 3, 0);
    add(0, 1, 0, 1, 2, 0, 1);
    add(0, 1, 0, 1, 2, 1, 0);
    add(0, 1, 0, 1, 3, 0, 1);
    // c held: FG exactly 20 cycles, period 52
    add(0, 1, 0, 19, 3, 19, 0);
    add(0, 1, 0, 1, 4, 0, 1);
    add(0, 1, 0, 4, 5, 0, 1);
    add(0, 1, 0, 2, 0, 0, 1);
    // next FG, drop c at FG cycle 3
    add(0, 1, 0, 26, 3, 0, 1);
    add(0, 1, 0, 3, 3, 3, 0);
    add(0, 0, 0, 1, 4, 0, 1);
    add(0, 0, 0, 3, 4, 3, 0);
    add(0, 0, 0, 1, 5, 0, 1);
    add(0, 0, 0, 1, 5, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1);
    // c toggling in HG before LONG_T has no effect
    add(0, 1, 0, 5, 0, 5, 0);
    add(0, 0, 0, 5, 0, 10, 0);
    add(0, 1, 0, 9, 0, 19, 0);
    // c drops during HY: sequence continues, FG lasts one cycle
    add(0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 0, 4, 2, 0, 1);
    add(0, 0, 0, 2, 3, 0, 1);
    add(0, 0, 0, 1, 4, 0, 1);
    // reset in FY at cnt 2
    add(0, 0, 0, 2, 4, 2, 0);
    add(1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 5, 0, 5, 0);
`ifdef NIGHT_MODE_EN
    add(0, 0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 3, 1, 3, 0);
    add(0, 0, 1, 1, 6, 0, 1, 1);
    add(0, 0, 1, 3, 6, 3, 0, 1);
    add(0, 0, 1, 1, 6, 0, 0, 0);
    add(0, 0, 1, 3, 6, 3, 0, 0);
    add(0, 0, 1, 1, 6, 0, 0, 1);
    add(0, 0, 0, 1, 5, 0, 1);
    add(0, 0, 0, 2, 0, 0, 1);
`endif
    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; c = tv[i].cv; night = tv[i].nv;
      repeat (tv[i].n) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tv[i].s, tv[i].cn, tv[i].st, tv[i].ph);
    end
    // c=0 for a long time: stays HG, no strobe, counter saturates
    reset = 1; c = 0; night = 0;
    @(posedge clk); #1;
    reset = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      checks++;
      if (state_o !== 3'd0 || st_o !== 1'b0 || !(HG && FR) || (HG && FG)) begin
        errors++;
        $display("FAIL hold%0d: got state=%0d st=%b HG=%b FR=%b FG=%b, want state=0 st=0 HG=1 FR=1 FG=0",
                 k, state_o, st_o, HG, FR, FG);
      end
    end
    check("saturate", 3'd0, 255, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
